// File: rtl/uart_comm_pkg.sv
// Shared constants, reply message builders and job field layout for the host link.
// Messages are 16-byte MSB-first buffers; len counts the valid leading bytes.
package uart_comm_pkg;

    localparam logic [7:0] MSG_INFO     = 8'h00;
    localparam logic [7:0] MSG_INVALID  = 8'h01;
    localparam logic [7:0] MSG_PUSH_JOB = 8'h02;
    localparam logic [7:0] MSG_NONCE    = 8'h03;

    localparam logic [7:0] PING = 8'h00;
    localparam logic [7:0] PONG = 8'h01;
    localparam logic [7:0] ACK  = 8'h01;

    localparam logic [63:0] INFO_PAYLOAD = 64'hDEADBEEF13370D13;

    localparam logic [7:0] INFO_LEN     = 8'd8;
    localparam logic [7:0] PUSH_JOB_LEN = 8'd60;

    localparam int NONCE_MAX_LSB = 0;
    localparam int NONCE_MIN_LSB = 32;
    localparam int WORK_DATA_LSB = 64;
    localparam int MIDSTATE_LSB  = 160;
    localparam int JOB_W         = 416;

    typedef enum logic [1:0] {
        RESP_PONG,
        RESP_ACK,
        RESP_INFO,
        RESP_INVALID
    } resp_t;

    typedef struct packed {
        logic [127:0] dat;
        logic [4:0]   len;
    } msg_t;

    function automatic msg_t resp_msg(input resp_t kind);
        msg_t m;
        m.dat = '0;
        m.len = 5'd1;
        case (kind)
            RESP_PONG: m.dat[127:120] = PONG;
            RESP_ACK:  m.dat[127:120] = ACK;
            RESP_INFO: begin
                m.dat = {8'h10, 16'h0000, MSG_INFO, INFO_PAYLOAD, 32'h0};
                m.len = 5'd16;
            end
            default: begin
                m.dat = {8'h08, 16'h0000, MSG_INVALID, 32'h0, 64'h0};
                m.len = 5'd8;
            end
        endcase
        return m;
    endfunction

    function automatic msg_t nonce_msg(input logic [31:0] nonce);
        msg_t m;
        m.dat = {8'h08, 16'h0000, MSG_NONCE, nonce, 64'h0};
        m.len = 5'd8;
        return m;
    endfunction

endpackage

// File: rtl/uart_phy.sv
// 8N1 byte serializer/deserializer; rx_vld pulses one cycle after the stop-bit sample.
// tx_rdy is low while a byte is on the line; rx has no backpressure (bad stop bit drops the byte).
module uart_phy #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_serial,
    output logic       rx_vld,
    output logic [7:0] rx_dat,
    input  logic       tx_vld,
    output logic       tx_rdy,
    input  logic [7:0] tx_dat,
    output logic       tx_serial
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bits_q, rx_bits_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_vld_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bits_d  = rx_bits_q;
        rx_shift_d = rx_shift_q;
        rx_vld_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF) begin
                rx_cnt_d   = '0;
                rx_bits_d  = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == FULL) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bits_d  = rx_bits_q + 3'd1;
                if (rx_bits_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == FULL) begin
                rx_vld_d   = rx_sync_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bits_q  <= '0;
            rx_shift_q <= '0;
            rx_vld     <= 1'b0;
        end else begin
            rx_meta_q  <= rx_serial;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bits_q  <= rx_bits_d;
            rx_shift_q <= rx_shift_d;
            rx_vld     <= rx_vld_d;
        end
    end

    assign rx_dat = rx_shift_q;

    // tx_shift holds the data bits followed by the stop bit; start bit is driven on accept
    logic          tx_busy_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_left_q;
    logic [8:0]    tx_shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_busy_q  <= 1'b0;
            tx_serial  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_left_q  <= '0;
            tx_shift_q <= '0;
        end else if (!tx_busy_q) begin
            if (tx_vld) begin
                tx_busy_q  <= 1'b1;
                tx_serial  <= 1'b0;
                tx_shift_q <= {1'b1, tx_dat};
                tx_left_q  <= 4'd9;
                tx_cnt_q   <= '0;
            end
        end else if (tx_cnt_q == FULL) begin
            tx_cnt_q <= '0;
            if (tx_left_q == 4'd0) begin
                tx_busy_q <= 1'b0;
            end else begin
                tx_serial  <= tx_shift_q[0];
                tx_shift_q <= {1'b0, tx_shift_q[8:1]};
                tx_left_q  <= tx_left_q - 4'd1;
            end
        end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
        end
    end

    assign tx_rdy = !tx_busy_q;

endmodule

// File: rtl/uart_comm.sv
// Host-link controller: frames/decodes UART commands, loads jobs, reports golden nonces.
// Reply starts <=4 cycles after the last stop-bit sample; one reply slot, newer command overwrites.
module uart_comm
    import uart_comm_pkg::*;
#(
    parameter int baud_rate    = 115200,
    parameter int sys_clk_freq = 100000000
) (
    input  logic         comm_clk,
    input  logic         reset,
    input  logic         rx_serial,
    output logic         tx_serial,
    input  logic         new_golden_nonce,
    input  logic [31:0]  golden_nonce,
    output logic         new_work,
    output logic [255:0] midstate,
    output logic [95:0]  work_data,
    output logic [31:0]  nonce_min,
    output logic [31:0]  nonce_max
);

    localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;

    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       tx_vld;
    logic       tx_rdy;
    logic [7:0] tx_dat;

    uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk       (comm_clk),
        .reset     (reset),
        .rx_serial (rx_serial),
        .rx_vld    (rx_vld),
        .rx_dat    (rx_dat),
        .tx_vld    (tx_vld),
        .tx_rdy    (tx_rdy),
        .tx_dat    (tx_dat),
        .tx_serial (tx_serial)
    );

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, EXEC} cmd_state_t;

    cmd_state_t       state_q, state_d;
    logic [7:0]       len_q, type_q, idx_q;
    logic [JOB_W-1:0] stage_q, job_q;
    logic             queue_vld, load_job;
    resp_t            queue_kind;

    function automatic logic len_ok(input logic [7:0] len);
        return (len[1:0] == 2'b00) && (len >= 8'd8) && (len <= 8'd60);
    endfunction

    always_comb begin
        state_d    = state_q;
        queue_vld  = 1'b0;
        queue_kind = RESP_INVALID;
        load_job   = 1'b0;
        case (state_q)
            IDLE: if (rx_vld) begin
                if (rx_dat == PING) begin
                    queue_vld  = 1'b1;
                    queue_kind = RESP_PONG;
                end else if (len_ok(rx_dat)) begin
                    state_d = HDR;
                end else begin
                    queue_vld = 1'b1;
                end
            end
            HDR:     if (rx_vld && idx_q == 8'd3) state_d = PAYLOAD;
            PAYLOAD: if (rx_vld && idx_q == len_q - 8'd1) state_d = EXEC;
            EXEC: begin
                state_d   = IDLE;
                queue_vld = 1'b1;
                if (type_q == MSG_PUSH_JOB && len_q == PUSH_JOB_LEN) begin
                    load_job   = 1'b1;
                    queue_kind = RESP_ACK;
                end else if (type_q == MSG_INFO && len_q == INFO_LEN) begin
                    queue_kind = RESP_INFO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload bytes enter at the MSB end so the first one ends up in bits [7:0]; CRC bytes are skipped
    always_ff @(posedge comm_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            type_q   <= '0;
            idx_q    <= '0;
            stage_q  <= '0;
            job_q    <= '0;
            new_work <= 1'b0;
        end else begin
            state_q  <= state_d;
            new_work <= load_job;
            if (rx_vld) begin
                if (state_q == IDLE) begin
                    len_q <= rx_dat;
                    idx_q <= 8'd1;
                end else begin
                    idx_q <= idx_q + 8'd1;
                    if (state_q == HDR && idx_q == 8'd3) type_q <= rx_dat;
                    if (state_q == PAYLOAD && idx_q < len_q - 8'd4)
                        stage_q <= {rx_dat, stage_q[JOB_W-1:8]};
                end
            end
            if (load_job) job_q <= stage_q;
        end
    end

    assign midstate  = job_q[JOB_W-1:MIDSTATE_LSB];
    assign work_data = job_q[MIDSTATE_LSB-1:WORK_DATA_LSB];
    assign nonce_min = job_q[WORK_DATA_LSB-1:NONCE_MIN_LSB];
    assign nonce_max = job_q[NONCE_MIN_LSB-1:NONCE_MAX_LSB];

    msg_t        slot_q, msg_q;
    logic        slot_pend_q, msg_active_q;
    logic        nonce_pend_q, gn_prev_q;
    logic [31:0] nonce_q;

    // Assignment order matters: a same-cycle load clears a pending flag before a new request re-sets it
    always_ff @(posedge comm_clk) begin
        if (reset) begin
            slot_q       <= '0;
            msg_q        <= '0;
            slot_pend_q  <= 1'b0;
            msg_active_q <= 1'b0;
            nonce_pend_q <= 1'b0;
            gn_prev_q    <= 1'b0;
            nonce_q      <= '0;
        end else begin
            if (msg_active_q) begin
                if (tx_rdy) begin
                    msg_q.dat <= {msg_q.dat[119:0], 8'h00};
                    msg_q.len <= msg_q.len - 5'd1;
                    if (msg_q.len == 5'd1) msg_active_q <= 1'b0;
                end
            end else if (slot_pend_q) begin
                msg_q        <= slot_q;
                msg_active_q <= 1'b1;
                slot_pend_q  <= 1'b0;
            end else if (nonce_pend_q) begin
                msg_q        <= nonce_msg(nonce_q);
                msg_active_q <= 1'b1;
                nonce_pend_q <= 1'b0;
            end
            if (queue_vld) begin
                slot_q      <= resp_msg(queue_kind);
                slot_pend_q <= 1'b1;
            end
            if (new_golden_nonce && !gn_prev_q) begin
                nonce_q      <= golden_nonce;
                nonce_pend_q <= 1'b1;
            end
            gn_prev_q <= new_golden_nonce;
        end
    end

    assign tx_vld = msg_active_q;
    assign tx_dat = msg_q.dat[127:120];

endmodule

// File: tb/tb_uart_comm.sv
// Directed bench for uart_comm at 16 clocks per bit: commands in, decoded replies and job fields out.
module tb_uart_comm;

    localparam int CPB = 16;

    logic         comm_clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_serial = 1'b1;
    logic         tx_serial;
    logic         new_golden_nonce = 1'b0;
    logic [31:0]  golden_nonce = '0;
    logic         new_work;
    logic [255:0] midstate;
    logic [95:0]  work_data;
    logic [31:0]  nonce_min;
    logic [31:0]  nonce_max;

    int nvec = 0;
    int nfail = 0;
    int new_work_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_comm #(.baud_rate(115200), .sys_clk_freq(1843200)) dut (
        .comm_clk         (comm_clk),
        .reset            (reset),
        .rx_serial        (rx_serial),
        .tx_serial        (tx_serial),
        .new_golden_nonce (new_golden_nonce),
        .golden_nonce     (golden_nonce),
        .new_work         (new_work),
        .midstate         (midstate),
        .work_data        (work_data),
        .nonce_min        (nonce_min),
        .nonce_max        (nonce_max)
    );

    initial forever #5 comm_clk = ~comm_clk;

    always @(negedge comm_clk) if (new_work === 1'b1) new_work_cnt++;

    // Host-side receiver: decodes bytes from tx_serial, sampling mid-bit
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge comm_clk);
            if (tx_serial === 1'b0) begin
                repeat (CPB / 2) @(negedge comm_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge comm_clk);
                    b[i] = tx_serial;
                end
                repeat (CPB) @(negedge comm_clk);
                got_q.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [415:0] obs, input logic [415:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge comm_clk);
            rx_serial = frame[i];
            repeat (CPB - 1) @(negedge comm_clk);
        end
        @(negedge comm_clk);
        rx_serial = 1'b1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3) * 10) @(negedge comm_clk);
    endtask

    task automatic send_word_le(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            gap();
        end
    endtask

    // Waits for the expected reply (bounded), then idles long enough to catch stray extra bytes
    task automatic expect_reply(input string tag);
        int n;
        int budget;
        n = exp_q.size();
        budget = 0;
        while (got_q.size() < n && budget < (n + 2) * 12 * CPB) begin
            @(negedge comm_clk);
            budget++;
        end
        repeat (30 * CPB) @(negedge comm_clk);
        chk({tag, " byte count"}, got_q.size(), n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s byte%0d", tag, i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        repeat (5) @(negedge comm_clk);
        chk("reset tx_serial", tx_serial, 1'b1);
        chk("reset new_work", new_work, 1'b0);
        chk("reset midstate", midstate, '0);
        chk("reset work_data", work_data, '0);
        chk("reset nonce_min", nonce_min, '0);
        chk("reset nonce_max", nonce_max, '0);
        reset = 1'b0;
        repeat (5) @(negedge comm_clk);

        send_byte(8'h00);
        exp_q = '{8'h01};
        expect_reply("ping");

        foreach (exp_q[i]) exp_q.delete();
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hF9); send_byte(8'hEA); send_byte(8'h98); send_byte(8'h0A);
        exp_q = '{8'h10, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  8'h13, 8'h37, 8'h0D, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_reply("get_info");

        send_byte(8'h06);
        exp_q = '{8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_reply("bad len");
        send_byte(8'h00);
        exp_q = '{8'h01};
        expect_reply("ping after bad len");

        send_byte(8'h00, 1'b0);
        expect_reply("framing error");

        send_word_le(32'h0200003C);
        send_word_le(32'h00000000);
        send_word_le(32'hFFFFFFFF);
        for (int k = 0; k < 11; k++) begin
            b = 8'(8 + 4 * k);
            send_word_le({b + 8'd3, b + 8'd2, b + 8'd1, b});
        end
        send_word_le(32'h4EC14D61);
        exp_q = '{8'h01};
        expect_reply("push_job ack");
        chk("new_work pulses", new_work_cnt, 1);
        chk("nonce_min", nonce_min, 32'hFFFFFFFF);
        chk("nonce_max", nonce_max, 32'h00000000);
        chk("work_data", work_data, 96'h131211100F0E0D0C0B0A0908);
        chk("midstate", midstate,
            256'h333231302F2E2D2C2B2A292827262524232221201F1E1D1C1B1A191817161514);

        golden_nonce = 32'h38B9B05A;
        new_golden_nonce = 1'b1;
        exp_q = '{8'h08, 8'h00, 8'h00, 8'h03, 8'h38, 8'hB9, 8'hB0, 8'h5A};
        expect_reply("nonce report");
        new_golden_nonce = 1'b0;

        send_word_le(32'h0200003C);
        for (int k = 0; k < 10; k++) begin
            send_byte(8'hA0 + 8'(k));
            gap();
        end
        reset = 1'b1;
        repeat (3) @(negedge comm_clk);
        reset = 1'b0;
        @(negedge comm_clk);
        chk("mid-job reset midstate", midstate, '0);
        chk("mid-job reset work_data", work_data, '0);
        chk("mid-job reset nonce_min", nonce_min, '0);
        chk("mid-job reset nonce_max", nonce_max, '0);
        chk("mid-job reset tx_serial", tx_serial, 1'b1);
        expect_reply("no reply after reset");
        send_byte(8'h00);
        exp_q = '{8'h01};
        expect_reply("ping after reset");
        chk("new_work total", new_work_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
